// File: rtl/cmp_pkg.sv
// Shared constants for the cascaded magnitude comparator: nibble width,
// {G,E,L} cascade codes and the sequencer state encoding.
package cmp_pkg;

   localparam int NIB_W = 4;

   localparam logic [2:0] CASC_GT = 3'b100;
   localparam logic [2:0] CASC_EQ = 3'b010;
   localparam logic [2:0] CASC_LT = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cmp4_slice.sv
// Combinational 4-bit magnitude comparator with {G,E,L} cascade in/out.
// A differing nibble decides the result; equal nibbles pass the cascade input through.
module cmp4_slice
   import cmp_pkg::*;
(
   input  logic [NIB_W-1:0] a4,
   input  logic [NIB_W-1:0] b4,
   input  logic             gi,
   input  logic             ei,
   input  logic             li,
   output logic             go,
   output logic             eo,
   output logic             lo
);

   always_comb begin
      {go, eo, lo} = {gi, ei, li};
      if (a4 > b4) begin
         {go, eo, lo} = CASC_GT;
      end else if (a4 < b4) begin
         {go, eo, lo} = CASC_LT;
      end
   end

endmodule

// File: rtl/cascade_compare_seq.sv
// Sequential WIDTH-bit comparator: one reused 4-bit slice, LSB nibble first, result after WIDTH/4 RUN cycles.
// start is accepted only in IDLE or DONE (back-to-back allowed); start during RUN is ignored.
module cascade_compare_seq
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
         $error("cascade_compare_seq: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       casc_q, casc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       res_q, res_d;

   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic             s_go, s_eo, s_lo;
   logic             accept;
   logic             last_nib;

   // idx*4 as a shift keeps the part-select base free of width mixing
   assign a_nib = a_q[{idx_q, 2'b00} +: NIB_W];
   assign b_nib = b_q[{idx_q, 2'b00} +: NIB_W];

   cmp4_slice u_slice (
      .a4 (a_nib),
      .b4 (b_nib),
      .gi (casc_q[2]),
      .ei (casc_q[1]),
      .li (casc_q[0]),
      .go (s_go),
      .eo (s_eo),
      .lo (s_lo)
   );

   assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign last_nib = (idx_q == IDX_W'(NIB - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      casc_d  = casc_q;
      idx_d   = idx_q;
      res_d   = res_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               a_d     = a;
               b_d     = b;
               casc_d  = CASC_EQ;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            casc_d = {s_go, s_eo, s_lo};
            if (last_nib) begin
               res_d   = {s_go, s_eo, s_lo};
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         casc_q  <= CASC_EQ;
         idx_q   <= '0;
         res_q   <= CASC_EQ;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         casc_q  <= casc_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
      end
   end

   assign busy         = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign {gt, eq, lt} = res_q;

endmodule

// File: tb/tb_cascade_compare_seq.sv
// Directed bench for cascade_compare_seq (WIDTH=16): inputs driven and outputs sampled on the falling edge.
module tb_cascade_compare_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic        gt;
   logic        eq;
   logic        lt;

   int          total;
   int          bad;
   logic [2:0]  prev_res;

   cascade_compare_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .gt    (gt),
      .eq    (eq),
      .lt    (lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a falling edge; returns at the falling edge of the DONE cycle.
   // When inject is set, a competing start is pulsed two cycles into RUN.
   task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [2:0] exp, input bit inject, input string nm);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (inject && i == 1) begin
            start = 1'b1;
            a     = 16'hFFFF;
            b     = 16'h0000;
         end
         if (inject && i == 2) begin
            a = 16'h0000;
            b = 16'hFFFF;
         end
         total++;
         if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL %s run%0d busy/done: got %b want 10", nm, i, {busy, done});
         end
         total++;
         if ({gt, eq, lt} !== prev_res) begin
            bad++;
            $display("FAIL %s run%0d result held: got %b want %b", nm, i, {gt, eq, lt}, prev_res);
         end
      end
      start = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b01) begin
         bad++;
         $display("FAIL %s done busy/done: got %b want 01", nm, {busy, done});
      end
      total++;
      if ({gt, eq, lt} !== exp) begin
         bad++;
         $display("FAIL %s result gt/eq/lt: got %b want %b", nm, {gt, eq, lt}, exp);
      end
      prev_res = exp;
   endtask

   // One idle cycle after DONE: done drops, result stays.
   task automatic check_idle_hold(input string nm);
      @(negedge clk);
      total++;
      if ({busy, done, gt, eq, lt} !== {2'b00, prev_res}) begin
         bad++;
         $display("FAIL %s idle hold: got %b want %b", nm, {busy, done, gt, eq, lt}, {2'b00, prev_res});
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      a     = 16'h0000;
      b     = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({busy, done, gt, eq, lt} !== 5'b00010) begin
         bad++;
         $display("FAIL reset_held outputs: got %b want 00010", {busy, done, gt, eq, lt});
      end
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, done, gt, eq, lt} !== 5'b00010) begin
         bad++;
         $display("FAIL reset_release outputs: got %b want 00010", {busy, done, gt, eq, lt});
      end
      prev_res = 3'b010;
   endtask

   task automatic test_equal();
      run_cmp(16'h1234, 16'h1234, 3'b010, 1'b0, "equal");
      check_idle_hold("equal");
   endtask

   task automatic test_msb_dominates();
      run_cmp(16'h8000, 16'h7FFF, 3'b100, 1'b0, "msb_dom");
      check_idle_hold("msb_dom");
   endtask

   task automatic test_lsb_tiebreak();
      run_cmp(16'h0001, 16'h0002, 3'b001, 1'b0, "lsb_lt");
      check_idle_hold("lsb_lt");
      run_cmp(16'hFFFE, 16'hFFFD, 3'b100, 1'b0, "lsb_gt");
      check_idle_hold("lsb_gt");
   endtask

   task automatic test_back_to_back();
      // 0x0010 vs 0x0020 is lt; injected 0xFFFF/0x0000 would be gt
      run_cmp(16'h0010, 16'h0020, 3'b001, 1'b1, "ignored_start");
      run_cmp(16'h0000, 16'h0000, 3'b010, 1'b0, "back_to_back");
      check_idle_hold("back_to_back");
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1;
      a     = 16'h5555;
      b     = 16'hAAAA;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, gt, eq, lt} !== 5'b00010) begin
         bad++;
         $display("FAIL reset_mid immediate: got %b want 00010", {busy, done, gt, eq, lt});
      end
      @(negedge clk);
      rst      = 1'b0;
      prev_res = 3'b010;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid quiet%0d busy/done: got %b want 00", i, {busy, done});
         end
      end
      run_cmp(16'hA000, 16'h0FFF, 3'b100, 1'b0, "after_reset");
      check_idle_hold("after_reset");
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      prev_res = 3'b010;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      test_reset();
      test_equal();
      test_msb_dominates();
      test_lsb_tiebreak();
      test_back_to_back();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
